// File: rtl/cp0_unit.sv
// Coprocessor-0 for a MIPS-style pipeline: SR, Cause and EPC, interrupt/exception request, mtc0/mfc0/eret.
// Optional macro CP0_PRID_EN makes register 15 read a constant PRId (0x0000_7007).
module cp0_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic        unused_cp0in;

  assign unused_cp0in = ^{CP0In[31:16], CP0In[9:2]};

  assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
  assign Req     = int_req | exc_req;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (Req) begin
      // Exception entry beats any mtc0 or eret in the same cycle.
      exl_d      = 1'b1;
      bd_d       = BDIn;
      exc_code_d = int_req ? 5'd0 : ExcCodeIn;
      epc_d      = BDIn ? (VPC - 32'd4) : VPC;
    end else begin
      if (en && (CP0Add == ADDR_SR)) begin
        im_d  = CP0In[15:10];
        exl_d = CP0In[1];
        ie_d  = CP0In[0];
      end
      if (en && (CP0Add == ADDR_EPC)) begin
        epc_d = CP0In;
      end
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
  assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
  assign EPCOut    = epc_q;

  always_comb begin
    CP0Out = 32'd0;
    case (CP0Add)
      ADDR_SR:    CP0Out = sr_val;
      ADDR_CAUSE: CP0Out = cause_val;
      ADDR_EPC:   CP0Out = epc_q;
`ifdef CP0_PRID_EN
      ADDR_PRID:  CP0Out = 32'h0000_7007;
`else
      ADDR_PRID:  CP0Out = 32'd0;
`endif
      default:    CP0Out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        Req;

  int vectors = 0;
  int miscompares = 0;

  cp0_unit dut (
    .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .CP0Out(CP0Out), .EPCOut(EPCOut), .Req(Req)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 0; CP0Add = 0; CP0In = 0; VPC = 0; BDIn = 0;
    ExcCodeIn = 0; HWInt = 0; EXLClr = 0;
  endtask

  task automatic test_reset();
    logic [4:0] a;
    idle();
    reset = 1; tick(); reset = 0;
    for (int i = 12; i <= 14; i++) begin
      a = i[4:0];
      CP0Add = a; #1;
      vectors++;
      if (CP0Out !== 32'd0) begin
        $display("FAIL reset_reg%0d got %h exp %h", i, CP0Out, 32'd0); miscompares++;
      end
    end
    vectors++;
    if (EPCOut !== 32'd0) begin $display("FAIL reset_epcout got %h exp 0", EPCOut); miscompares++; end
    vectors++;
    if (Req !== 1'b0) begin $display("FAIL reset_req got %b exp 0", Req); miscompares++; end
  endtask

  task automatic test_exception();
    ExcCodeIn = 5'd4; VPC = 32'h3004; BDIn = 0; #1;
    vectors++;
    if (Req !== 1'b1) begin $display("FAIL exc_req got %b exp 1", Req); miscompares++; end
    tick(); idle();
    vectors++;
    if (EPCOut !== 32'h3004) begin $display("FAIL exc_epc got %h exp 00003004", EPCOut); miscompares++; end
    CP0Add = 13; #1; vectors++;
    if (CP0Out !== 32'h10) begin $display("FAIL exc_cause got %h exp 00000010", CP0Out); miscompares++; end
    CP0Add = 12; #1; vectors++;
    if (CP0Out !== 32'h2) begin $display("FAIL exc_sr got %h exp 00000002", CP0Out); miscompares++; end
  endtask

  task automatic test_interrupt();
    en = 1; CP0Add = 12; CP0In = 32'h0000_0401; tick(); idle();
    CP0Add = 12; #1; vectors++;
    if (CP0Out !== 32'h401) begin $display("FAIL mtc0_sr got %h exp 00000401", CP0Out); miscompares++; end
    HWInt = 6'b000001; ExcCodeIn = 5'd8; VPC = 32'h3020; #1; vectors++;
    if (Req !== 1'b1) begin $display("FAIL int_req got %b exp 1", Req); miscompares++; end
    tick(); idle();
    CP0Add = 13; #1; vectors++;
    if (CP0Out !== 32'h400) begin $display("FAIL int_cause got %h exp 00000400", CP0Out); miscompares++; end
    CP0Add = 12; #1; vectors++;
    if (CP0Out !== 32'h403) begin $display("FAIL int_sr got %h exp 00000403", CP0Out); miscompares++; end
    vectors++;
    if (EPCOut !== 32'h3020) begin $display("FAIL int_epc got %h exp 00003020", EPCOut); miscompares++; end
  endtask

  task automatic test_branch_delay();
    EXLClr = 1; tick(); idle();
    CP0Add = 12; #1; vectors++;
    if (CP0Out !== 32'h401) begin $display("FAIL eret_sr got %h exp 00000401", CP0Out); miscompares++; end
    ExcCodeIn = 5'd10; VPC = 32'h3010; BDIn = 1; #1; vectors++;
    if (Req !== 1'b1) begin $display("FAIL bd_req got %b exp 1", Req); miscompares++; end
    tick(); idle();
    vectors++;
    if (EPCOut !== 32'h300C) begin $display("FAIL bd_epc got %h exp 0000300c", EPCOut); miscompares++; end
    CP0Add = 13; #1; vectors++;
    if (CP0Out !== 32'h8000_0028) begin $display("FAIL bd_cause got %h exp 80000028", CP0Out); miscompares++; end
  endtask

  task automatic test_no_nest();
    ExcCodeIn = 5'd12; VPC = 32'h3080; HWInt = 6'b000001; #1; vectors++;
    if (Req !== 1'b0) begin $display("FAIL nest_req got %b exp 0", Req); miscompares++; end
    HWInt = 0; tick();
    vectors++;
    if (EPCOut !== 32'h300C) begin $display("FAIL nest_epc got %h exp 0000300c", EPCOut); miscompares++; end
    EXLClr = 1; tick(); EXLClr = 0;
    CP0Add = 12; #1; vectors++;
    if (CP0Out !== 32'h401) begin $display("FAIL eret_exl got %h exp 00000401", CP0Out); miscompares++; end
    vectors++;
    if (Req !== 1'b1) begin $display("FAIL pending_req got %b exp 1", Req); miscompares++; end
    EXLClr = 1; VPC = 32'h3040; tick(); idle();
    CP0Add = 12; #1; vectors++;
    if (CP0Out !== 32'h403) begin $display("FAIL eret_vs_req_sr got %h exp 00000403", CP0Out); miscompares++; end
    CP0Add = 13; #1; vectors++;
    if (CP0Out !== 32'h30) begin $display("FAIL eret_vs_req_cause got %h exp 00000030", CP0Out); miscompares++; end
    vectors++;
    if (EPCOut !== 32'h3040) begin $display("FAIL eret_vs_req_epc got %h exp 00003040", EPCOut); miscompares++; end
  endtask

  task automatic test_writes();
    EXLClr = 1; tick(); idle();
    en = 1; CP0Add = 14; CP0In = 32'h1234; ExcCodeIn = 5'd4; VPC = 32'h3000; #1; vectors++;
    if (Req !== 1'b1) begin $display("FAIL drop_req got %b exp 1", Req); miscompares++; end
    tick(); idle();
    vectors++;
    if (EPCOut !== 32'h3000) begin $display("FAIL drop_epc got %h exp 00003000", EPCOut); miscompares++; end
    en = 1; CP0Add = 14; CP0In = 32'h1234; tick(); idle();
    vectors++;
    if (EPCOut !== 32'h1234) begin $display("FAIL mtc0_epc got %h exp 00001234", EPCOut); miscompares++; end
    en = 1; CP0Add = 13; CP0In = 32'hFFFF_FFFF; tick(); idle();
    CP0Add = 13; #1; vectors++;
    if (CP0Out !== 32'h10) begin $display("FAIL cause_ro got %h exp 00000010", CP0Out); miscompares++; end
    en = 1; CP0Add = 12; CP0In = 32'hFFFF_FFFF; EXLClr = 1; tick(); idle();
    CP0Add = 12; #1; vectors++;
    if (CP0Out !== 32'hFC01) begin $display("FAIL sr_eret_write got %h exp 0000fc01", CP0Out); miscompares++; end
  endtask

  task automatic test_prid();
    logic [31:0] exp_prid;
`ifdef CP0_PRID_EN
    exp_prid = 32'h0000_7007;
`else
    exp_prid = 32'h0;
`endif
    en = 1; CP0Add = 15; CP0In = 32'hDEAD_BEEF; tick(); idle();
    CP0Add = 15; #1; vectors++;
    if (CP0Out !== exp_prid) begin $display("FAIL prid got %h exp %h", CP0Out, exp_prid); miscompares++; end
    CP0Add = 16; #1; vectors++;
    if (CP0Out !== 32'h0) begin $display("FAIL other_addr got %h exp 0", CP0Out); miscompares++; end
  endtask

  task automatic test_reset_override();
    en = 1; CP0Add = 14; CP0In = 32'h5555; ExcCodeIn = 5'd4; VPC = 32'h3000;
    EXLClr = 1; HWInt = 6'h3F; reset = 1; tick(); reset = 0; idle();
    vectors++;
    if (EPCOut !== 32'h0) begin $display("FAIL rst_ovr_epc got %h exp 0", EPCOut); miscompares++; end
    CP0Add = 12; #1; vectors++;
    if (CP0Out !== 32'h0) begin $display("FAIL rst_ovr_sr got %h exp 0", CP0Out); miscompares++; end
    CP0Add = 13; #1; vectors++;
    if (CP0Out !== 32'h0) begin $display("FAIL rst_ovr_cause got %h exp 0", CP0Out); miscompares++; end
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_exception();
    test_interrupt();
    test_branch_delay();
    test_no_nest();
    test_writes();
    test_prid();
    test_reset_override();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
